ifu_fetch: RTL

Instruction fetch unit for the single-issue NPC core; the producer end of the instruction stream the decode stage consumes. It holds the PC and issues one word fetch at a time to instruction memory over a valid/ready request and valid response channel. It presents each fetched instruction with its PC to decode over a valid/ready handshake, and handles control-flow redirects and trap halt.

---
 rtl/npc_pkg.sv | 17 +
 rtl/ifu_fetch.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core front end.
// Holds the reset PC default, datapath widths and the fetch state encoding.
package npc_pkg;

    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD,
        HALTED
    } fetch_state_e;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: keeps the PC, issues one word fetch at a time and
// hands each instruction with its PC to decode, with redirect and halt.
// Ports: clk/rst (sync, active-high); imem_req_valid/ready/addr request
// channel; imem_rsp_valid/data response; inst_valid/ready/inst/inst_pc to
// decode; redirect_valid/redirect_pc; halt in; misaligned/halted status.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [XLEN-1:0]       imem_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [INST_WIDTH-1:0] inst,
    output logic [XLEN-1:0]       inst_pc,
    input  logic                  redirect_valid,
    input  logic [XLEN-1:0]       redirect_pc,
    input  logic                  halt,
    output logic                  misaligned,
    output logic                  halted
);

    fetch_state_e          state, state_n;
    logic [XLEN-1:0]       pc, pc_n;
    // addr is the address of the current request; it is held while the
    // request is pending so a redirect cannot move it before acceptance.
    logic [XLEN-1:0]       addr, addr_n;
    logic                  kill, kill_n;
    // halt seen while a request is in flight; resolved when it returns
    logic                  hpend, hpend_n;
    logic                  mis_n;
    logic [INST_WIDTH-1:0] inst_n;
    logic [XLEN-1:0]       inst_pc_n;
    logic                  acc;
    logic                  redir;
    logic [XLEN-1:0]       rpc;

    assign imem_req_valid = (state == REQ);
    assign imem_addr      = addr;
    assign inst_valid     = (state == HOLD);
    assign halted         = (state == HALTED);

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        addr_n    = addr;
        kill_n    = kill;
        hpend_n   = hpend;
        mis_n     = misaligned;
        inst_n    = inst;
        inst_pc_n = inst_pc;
        acc       = (state == REQ) && imem_req_ready;
        rpc       = {redirect_pc[XLEN-1:2], 2'b00};
        // halt outranks redirect, and nothing moves the PC once halting
        redir     = redirect_valid && !halt && !hpend && (state != HALTED);

        if (redir) begin
            pc_n = rpc;
            if (redirect_pc[1:0] != 2'b00) mis_n = 1'b1;
        end

        unique case (state)
            REQ: begin
                if (halt) begin
                    if (acc) begin
                        state_n = WAIT;
                        kill_n  = 1'b1;
                        hpend_n = 1'b1;
                    end else begin
                        state_n = HALTED;
                    end
                end else if (acc) begin
                    state_n = WAIT;
                    if (redir) kill_n = 1'b1;
                end else if (redir) begin
                    kill_n = 1'b1;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    kill_n = 1'b0;
                    if (halt || hpend) begin
                        state_n = HALTED;
                        hpend_n = 1'b0;
                    end else if (kill || redir) begin
                        state_n = REQ;
                        addr_n  = pc_n;
                    end else begin
                        state_n   = HOLD;
                        inst_n    = imem_rsp_data;
                        inst_pc_n = pc;
                    end
                end else if (halt) begin
                    hpend_n = 1'b1;
                end else if (redir) begin
                    kill_n = 1'b1;
                end
            end
            HOLD: begin
                if (halt) begin
                    state_n = HALTED;
                end else if (redir) begin
                    state_n = REQ;
                    addr_n  = rpc;
                end else if (inst_ready) begin
                    state_n = REQ;
                    pc_n    = pc + 32'd4;
                    addr_n  = pc + 32'd4;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REQ;
            pc         <= RESET_PC;
            addr       <= RESET_PC;
            kill       <= 1'b0;
            hpend      <= 1'b0;
            misaligned <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            addr       <= addr_n;
            kill       <= kill_n;
            hpend      <= hpend_n;
            misaligned <= mis_n;
            inst       <= inst_n;
            inst_pc    <= inst_pc_n;
        end
    end

endmodule
